// File: rtl/fact_sched.sv
// Round-robin scheduler around one iterative factorial engine. A single multiplier
// steps one multiply per clock, and the truncated result leaves through a valid/ready port.
module fact_sched #(
  parameter int N_W = 10,
  parameter int R_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [N_W-1:0] req0_num,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N_W-1:0] req1_num,
  output logic           req1_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [R_W-1:0] rsp_result,
  output logic           rsp_ovf,
  output logic           rsp_id,
  output logic           busy
);

  localparam int P_W = R_W + N_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [N_W-1:0] num_q, num_d;
  logic           id_q, id_d;
  logic [R_W-1:0] acc_q, acc_d;
  logic [N_W:0]   i_q, i_d;
  logic           ovf_q, ovf_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [R_W-1:0] rsp_result_q, rsp_result_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic           rsp_id_q, rsp_id_d;

  logic           grant;
  logic           accept;
  logic           calc_end;
  logic           prod_zero;
  logic [P_W-1:0] prod;

  // Tie goes to the requester that was not served last.
  assign grant  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign prod      = {{(P_W-R_W){1'b0}}, acc_q} * {{(P_W-N_W-1){1'b0}}, i_q};
  assign calc_end  = (i_q > {1'b0, num_q});
  assign prod_zero = (prod[R_W-1:0] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (calc_end || prod_zero) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && (grant == 1'b0);
    req1_ready = (state_q == IDLE) && (grant == 1'b1);
    busy       = (state_q != IDLE);
  end

  always_comb begin
    last_d       = last_q;
    num_d        = num_q;
    id_d         = id_q;
    acc_d        = acc_q;
    i_d          = i_q;
    ovf_d        = ovf_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_id_d     = rsp_id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          num_d = grant ? req1_num : req0_num;
          id_d  = grant;
          acc_d = {{(R_W-1){1'b0}}, 1'b1};
          i_d   = (N_W+1)'(2);
          ovf_d = 1'b0;
        end
      end
      CALC: begin
        if (!calc_end) begin
          acc_d = prod[R_W-1:0];
          ovf_d = ovf_q | (prod[P_W-1:R_W] != '0);
          i_d   = i_q + (N_W+1)'(1);
        end
        // Snapshot into the response registers on the way into DONE.
        if (calc_end || prod_zero) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = acc_d;
          rsp_ovf_d    = ovf_d;
          rsp_id_d     = id_q;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_d      = id_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= 1'b1;
      num_q        <= '0;
      id_q         <= 1'b0;
      acc_q        <= {{(R_W-1){1'b0}}, 1'b1};
      i_q          <= (N_W+1)'(2);
      ovf_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      last_q       <= last_d;
      num_q        <= num_d;
      id_q         <= id_d;
      acc_q        <= acc_d;
      i_q          <= i_d;
      ovf_q        <= ovf_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: doc/fact_sched.md
# fact_sched

Two-port scheduler and sequencer for the calculator's factorial resource. Two requesters (keypad entry path, memory-recall path) share one iterative factorial engine built around a single multiplier. The block arbitrates round-robin, steps one multiply per clock, and returns the truncated result with an overflow flag through a valid/ready response port. It replaces per-requester combinational factorial chains with one registered, multi-cycle datapath.

## Interface
- N_W, 10: operand width.
- R_W, 12: result width; the result is num! mod 2^R_W.
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req0_valid  in  1: requester 0 has an operand.
- req0_num  in  N_W: requester 0 operand.
- req0_ready  out  1: requester 0 accepted on this edge if req0_valid is high.
- req1_valid, req1_num, req1_ready: same as the req0 ports, for requester 1.
- rsp_valid  out  1: response available.
- rsp_ready  in  1: consumer takes the response.
- rsp_result  out  R_W: num! mod 2^R_W.
- rsp_ovf  out  1: true num! ≥ 2^R_W.
- rsp_id  out  1: index of the requester served.
- busy  out  1: state ≠ IDLE.

## Operation
- States are IDLE, CALC and DONE.
- Grant is combinational in IDLE.
  - If only one request is valid, that requester is granted.
  - If both are valid, the requester ≠ `last` is granted.
  - `last` is a register updated when a response is consumed.
- reqK_ready = (state==IDLE) && grant==K. It is low in CALC and DONE.
- Accept edge (reqK_valid && reqK_ready):
  - capture num_q ← reqK_num and id_q ← K;
  - set acc ← 1, i ← 2, ovf ← 0;
  - go to CALC.
- Each CALC edge:
  - If i > num_q, go to DONE with no multiply.
  - Otherwise form p = acc*i at full width (R_W+N_W+1 bits), then:
    - acc ← p[R_W-1:0];
    - ovf ← ovf | (p ≥ 2^R_W);
    - if p[R_W-1:0]==0, go to DONE (early exit: the product stays 0 from here);
    - else i ← i+1.
- The i counter is N_W+1 bits wide, so num_q = 2^N_W−1 does not wrap.
- DONE:
  - rsp_valid=1; rsp_result=acc, rsp_ovf=ovf, rsp_id=id_q, all held stable.
  - On the edge with rsp_valid && rsp_ready: last ← id_q, go to IDLE.
  - While rsp_ready is low, the block stalls indefinitely with outputs unchanged.
- No new request is accepted while in DONE. The earliest next accept is the cycle after the response handshake.
- Reset values: state IDLE, last=1 (requester 0 wins the first tie), rsp_valid=0, rsp_result=0, rsp_ovf=0, rsp_id=0, busy=0, acc=1, i=2, num_q=0.
- Reset mid-operation aborts the request immediately. No response is produced for it, and the requester must resubmit.
- Request inputs are ignored outside IDLE. A requester keeps valid high until it sees ready.

## Timing
- Edges are counted from the accept edge E0.
- rsp_valid rises after edge E(max(num,1)), with early exit as the exception:
  - num 0/1: DONE after E1.
  - num=n in 2..15: DONE after En (multiply for i=k happens at E(k−1)).
  - R_W=12, num ≥ 16: the product is 0 at i=16, so DONE after E15.
- The response is consumed at the handshake edge. IDLE and ready follow in the next cycle.
- Minimum request-to-request spacing is therefore latency + 1 edge (the IDLE cycle).
- busy is high from the cycle after E0 through the handshake edge.
- All outputs are registered except req0_ready, req1_ready and busy; busy is decoded from state only.

## Test plan
- req0 num=5, rsp_ready=1 → rsp_valid after E5; rsp_result=120, rsp_ovf=0, rsp_id=0.
- req1 num=7 → rsp_result=944 (5040 mod 4096), rsp_ovf=1, rsp_id=1; num=6 → 720, rsp_ovf=0.
- num=0 and num=1 → rsp_result=1, rsp_ovf=0, rsp_valid after E1. num=20 → rsp_result=0, rsp_ovf=1, rsp_valid after E15 (early exit). num=1023 → rsp_result=0, rsp_ovf=1, rsp_valid after E15; the i counter does not wrap.
- Both requesters valid continuously, with differing num → responses strictly alternate 0,1,0,1 from reset. A single-requester stream is served back to back.
- Hold rsp_ready=0 for 10 cycles in DONE → outputs stable, both readies low, new requests not accepted. Release → IDLE next cycle.
- Assert rst_n low during CALC (num=9) → all outputs reach reset values asynchronously. Resubmit after reset → rsp_result=362880 mod 4096 = 2432, rsp_ovf=1.
